// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
// Checksum support is enabled by the LOADER_CHECKSUM_EN macro.
package loader_pkg;

    localparam int unsigned LOADER_BYTES_PER_WORD = 4;

    typedef logic [31:0] arch_reg_t;

    typedef enum logic [2:0] {
        StLen,
        StData,
        StWrite,
        StCheck,
        StDone,
        StError
    } loader_state_t;

endpackage

// File: rtl/byte_assembler.sv
// Little-endian byte-to-word shifter: the first byte lands in bits [7:0].
// o_word/o_word_valid are combinational on the 4th accepted byte.
module byte_assembler
    import loader_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    input  logic      i_clear,
    input  logic      i_valid,
    input  logic [7:0] i_byte,
    output arch_reg_t o_word,
    output logic      o_word_valid
);

    logic [1:0]  r_idx;
    logic [23:0] r_shift;
    logic        w_last;

    assign w_last       = (r_idx == 2'(LOADER_BYTES_PER_WORD - 1));
    assign o_word       = {i_byte, r_shift};
    assign o_word_valid = i_valid && w_last;

    always_ff @(posedge clock) begin
        if (!reset || i_clear) begin
            r_idx   <= '0;
            r_shift <= '0;
        end else if (i_valid) begin
            r_shift <= {i_byte, r_shift[23:8]};
            r_idx   <= r_idx + 2'd1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed little-endian image into the core setup port.
// Define LOADER_CHECKSUM_EN to require a trailing 32-bit sum of all data words.
module program_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 4096
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        setup_write,
    output arch_reg_t   setup_address,
    output arch_reg_t   setup_data_in,
    output logic        core_hold,
    output logic        load_done,
    output logic        load_error,
    output logic [31:0] words_loaded
);

    loader_state_t r_state;
    logic [31:0]   r_n;
    logic [31:0]   r_words_loaded;
    logic          r_setup_write;
    arch_reg_t     r_setup_address;
    arch_reg_t     r_setup_data;
    logic          r_core_hold;
    logic          r_load_done;
    logic          r_load_error;
`ifdef LOADER_CHECKSUM_EN
    arch_reg_t     r_checksum;
`endif

    logic      w_accept;
    logic      w_clear;
    logic      w_word_valid;
    arch_reg_t w_word;

    assign in_ready = (r_state == StLen) || (r_state == StData) || (r_state == StCheck);
    assign w_accept = in_valid && in_ready;
    assign w_clear  = (r_state == StDone) || (r_state == StError);

    byte_assembler u_byte_assembler (
        .clock        (clock),
        .reset        (reset),
        .i_clear      (w_clear),
        .i_valid      (w_accept),
        .i_byte       (in_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state         <= StLen;
            r_n             <= '0;
            r_words_loaded  <= '0;
            r_setup_write   <= 1'b0;
            r_setup_address <= '0;
            r_setup_data    <= '0;
            r_core_hold     <= 1'b1;
            r_load_done     <= 1'b0;
            r_load_error    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_checksum      <= '0;
`endif
        end else begin
            r_setup_write <= 1'b0;
            case (r_state)
                StLen: begin
                    if (w_word_valid) begin
                        r_n <= w_word;
                        if (w_word == '0) begin
`ifdef LOADER_CHECKSUM_EN
                            r_state     <= StCheck;
`else
                            r_state     <= StDone;
                            r_core_hold <= 1'b0;
                            r_load_done <= 1'b1;
`endif
                        end else if (w_word > arch_reg_t'(MAX_WORDS)) begin
                            r_state      <= StError;
                            r_load_error <= 1'b1;
                        end else begin
                            r_state <= StData;
                        end
                    end
                end
                StData: begin
                    if (w_word_valid) begin
                        r_setup_write   <= 1'b1;
                        r_setup_address <= BASE_ADDR
                                         + r_words_loaded * arch_reg_t'(LOADER_BYTES_PER_WORD);
                        r_setup_data    <= w_word;
                        r_state         <= StWrite;
                    end
                end
                StWrite: begin
                    r_words_loaded <= r_words_loaded + 32'd1;
`ifdef LOADER_CHECKSUM_EN
                    r_checksum     <= r_checksum + r_setup_data;
`endif
                    if (r_words_loaded + 32'd1 < r_n) begin
                        r_state <= StData;
                    end else begin
`ifdef LOADER_CHECKSUM_EN
                        r_state     <= StCheck;
`else
                        r_state     <= StDone;
                        r_core_hold <= 1'b0;
                        r_load_done <= 1'b1;
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                StCheck: begin
                    if (w_word_valid) begin
                        if (w_word == r_checksum) begin
                            r_state     <= StDone;
                            r_core_hold <= 1'b0;
                            r_load_done <= 1'b1;
                        end else begin
                            r_state      <= StError;
                            r_load_error <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    // DONE and ERROR are terminal until reset.
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign setup_write   = r_setup_write;
    assign setup_address = r_setup_address;
    assign setup_data_in = r_setup_data;
    assign core_hold     = r_core_hold;
    assign load_done     = r_load_done;
    assign load_error    = r_load_error;
    assign words_loaded  = r_words_loaded;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader; follows LOADER_CHECKSUM_EN if defined.
module tb_program_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int unsigned MAXW = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        setup_write;
    logic [31:0] setup_address;
    logic [31:0] setup_data_in;
    logic        core_hold;
    logic        load_done;
    logic        load_error;
    logic [31:0] words_loaded;

    int total = 0;
    int bad   = 0;

    logic [31:0] img[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int cyc = 0;
    int last_wr_cyc = -1;
    int first_free_cyc = -1;

    typedef struct {
        logic [31:0] n;
        int          gap;
        int          ck_delta;
        bit          exp_done;
        bit          exp_err;
        int unsigned exp_cnt;
    } vec_t;
    vec_t vecs[$];

    program_loader #(
        .BASE_ADDR (BASE),
        .MAX_WORDS (MAXW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .setup_write   (setup_write),
        .setup_address (setup_address),
        .setup_data_in (setup_data_in),
        .core_hold     (core_hold),
        .load_done     (load_done),
        .load_error    (load_error),
        .words_loaded  (words_loaded)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Write log and core_hold release timing, sampled mid-cycle.
    always @(negedge clock) begin
        cyc++;
        if (reset === 1'b1) begin
            if (setup_write === 1'b1) begin
                wr_addr.push_back(setup_address);
                wr_data.push_back(setup_data_in);
                last_wr_cyc = cyc;
                chk("ready_in_write", {31'b0, in_ready}, 32'd0);
            end
            if (core_hold === 1'b0 && first_free_cyc < 0) first_free_cyc = cyc;
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, {31'b0, in_ready}, 32'd1);
        chk({tag, "_wr"}, {31'b0, setup_write}, 32'd0);
        chk({tag, "_addr"}, setup_address, 32'd0);
        chk({tag, "_data"}, setup_data_in, 32'd0);
        chk({tag, "_hold"}, {31'b0, core_hold}, 32'd1);
        chk({tag, "_done"}, {31'b0, load_done}, 32'd0);
        chk({tag, "_err"}, {31'b0, load_error}, 32'd0);
        chk({tag, "_cnt"}, words_loaded, 32'd0);
    endtask

    task automatic reset_dut();
        in_valid = 1'b0;
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check_reset_vals("rst");
        wr_addr.delete();
        wr_data.delete();
        last_wr_cyc = -1;
        first_free_cyc = -1;
        reset = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int budget;
        int g;
        g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        repeat (g) @(negedge clock);
        budget = 0;
        @(negedge clock);
        while (!in_ready && budget < 20) begin
            @(negedge clock);
            budget++;
        end
        if (!in_ready) begin
            chk("ready_timeout", {31'b0, in_ready}, 32'd1);
            return;
        end
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clock);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
    endtask

    // Model: a legal image writes word i to BASE+4*i; an oversize one writes nothing.
    task automatic load_and_check(input logic [31:0] n, input int gap, input int ck_delta,
                                  input bit exp_done, input bit exp_err,
                                  input int unsigned exp_cnt);
        logic [31:0] sum;
        int unsigned ncmp;
        send_word(n, gap);
        if (n <= MAXW) begin
            sum = '0;
            for (int i = 0; i < int'(n); i++) begin
                send_word(img[i], gap);
                sum = sum + img[i];
            end
`ifdef LOADER_CHECKSUM_EN
            send_word(sum + 32'(ck_delta), gap);
`else
            if (ck_delta != 0 || sum == 32'hx) $display("note: checksum feature off");
`endif
        end
        repeat (3) @(negedge clock);
        chk("load_done", {31'b0, load_done}, {31'b0, exp_done});
        chk("load_error", {31'b0, load_error}, {31'b0, exp_err});
        chk("core_hold", {31'b0, core_hold}, {31'b0, !exp_done});
        chk("words_loaded", words_loaded, exp_cnt);
        chk("ready_terminal", {31'b0, in_ready}, 32'd0);
        chk("n_writes", wr_addr.size(), exp_cnt);
        ncmp = (wr_addr.size() < exp_cnt) ? wr_addr.size() : exp_cnt;
        for (int i = 0; i < int'(ncmp); i++) begin
            chk("wr_addr", wr_addr[i], BASE + 32'(4 * i));
            chk("wr_data", wr_data[i], img[i]);
        end
        if (exp_cnt > 0) begin
            chk("hold_addr", setup_address, BASE + 32'(4 * (exp_cnt - 1)));
            chk("hold_data", setup_data_in, img[exp_cnt-1]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required $finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] n;
        int          ck;
        bit          ok;
        in_valid = 1'b0;
        in_data  = '0;
        reset    = 1'b0;

        // Table of hand-derived images.
        vecs.push_back('{32'd0,         0, 0, 1'b1, 1'b0, 0});
        vecs.push_back('{32'd1,         0, 0, 1'b1, 1'b0, 1});
        vecs.push_back('{32'd3,         1, 0, 1'b1, 1'b0, 3});
        vecs.push_back('{MAXW,          0, 0, 1'b1, 1'b0, MAXW});
        vecs.push_back('{MAXW + 1,      0, 0, 1'b0, 1'b1, 0});
        vecs.push_back('{32'hFFFF_FFFF, 0, 0, 1'b0, 1'b1, 0});
`ifdef LOADER_CHECKSUM_EN
        vecs.push_back('{32'd2,         0, 1, 1'b0, 1'b1, 2});
`endif
        foreach (vecs[v]) begin
            img.delete();
            for (int i = 0; i < 20; i++) img.push_back($urandom());
            reset_dut();
            load_and_check(vecs[v].n, vecs[v].gap, vecs[v].ck_delta,
                           vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_cnt);
        end

        // Two-instruction image, back to back and with alternating gaps.
        for (int g = 0; g < 2; g++) begin
            img.delete();
            img.push_back(32'h0000_0093);
            img.push_back(32'h0010_0113);
            reset_dut();
            load_and_check(32'd2, g, 0, 1'b1, 1'b0, 2);
`ifndef LOADER_CHECKSUM_EN
            chk("hold_release_lat", 32'(first_free_cyc - last_wr_cyc), 32'd1);
`endif
        end

`ifdef LOADER_CHECKSUM_EN
        img.delete();
        img.push_back(32'd1);
        img.push_back(32'd2);
        reset_dut();
        load_and_check(32'd2, 0, 0, 1'b1, 1'b0, 2);
        reset_dut();
        load_and_check(32'd2, 0, 1, 1'b0, 1'b1, 2);
`endif

        // Reset mid-word discards the partial word; a fresh image then loads cleanly.
        img.delete();
        img.push_back(32'hDEAD_BEEF);
        img.push_back(32'h1234_5678);
        reset_dut();
        send_word(32'd2, 0);
        send_byte(8'h93, 0);
        send_byte(8'h00, 0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check_reset_vals("midrst");
        reset = 1'b1;
        load_and_check(32'd2, 0, 0, 1'b1, 1'b0, 2);

        // Randomised images against the model.
        for (int t = 0; t < 12; t++) begin
            n = 32'($urandom_range(0, MAXW + 1));
`ifdef LOADER_CHECKSUM_EN
            ck = ($urandom_range(0, 3) == 0) ? 5 : 0;
`else
            ck = 0;
`endif
            img.delete();
            for (int i = 0; i < int'(MAXW); i++) img.push_back($urandom());
            ok = (n <= MAXW) && (ck == 0);
            reset_dut();
            load_and_check(n, -1, ck, ok, !ok, (n <= MAXW) ? n : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter BASE_ADDR, 32'h0000_0000: byte address of the first loaded word.
REQ-002 Parameter MAX_WORDS, 4096: largest legal word count.
REQ-003 clock  input  1  single clock for all state.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 in_valid  input  1  the source presents a byte on in_data.
REQ-006 in_data  input  8  stream byte.
REQ-007 in_ready  output  1  the loader accepts in_data this cycle.
REQ-008 setup_write  output  1  one-cycle memory write strobe to the core setup port.
REQ-009 setup_address  output  32  byte address of the write.
REQ-010 setup_data_in  output  32  write data.
REQ-011 core_hold  output  1  while 1, the core is held in reset.
REQ-012 load_done  output  1  the image was loaded successfully (sticky).
REQ-013 load_error  output  1  the image was rejected (sticky).
REQ-014 words_loaded  output  32  count of words written so far.

Function
REQ-015 A byte transfers only when in_valid and in_ready are both high at a rising clock edge.
REQ-016 Stream format: 4-byte word count N, little-endian, followed by N data words, each little-endian (first byte goes to bits [7:0]).
REQ-017 FSM states: LEN, DATA, WRITE, CHECK, DONE, ERROR.
REQ-018 LEN: assemble 4 bytes into N.
- N==0 -> DONE (CHECK if the checksum feature is enabled).
- N>MAX_WORDS -> ERROR.
- Otherwise -> DATA.
REQ-019 DATA: assemble 4 bytes; on the 4th accepted byte -> WRITE.
REQ-020 WRITE lasts exactly one cycle:
- setup_write=1, setup_address=BASE_ADDR+4*words_loaded, setup_data_in=the assembled word, in_ready=0.
- words_loaded increments at the end of the cycle.
- Next state: DATA if words_loaded+1<N, else CHECK (feature enabled) or DONE.
REQ-021 setup_write is 1 only in WRITE; setup_address/setup_data_in hold their last value otherwise.
REQ-022 in_ready=1 in LEN, DATA and CHECK; 0 in WRITE, DONE and ERROR.
REQ-023 core_hold=1 in every state except DONE; it deasserts on the first DONE cycle.
REQ-024 DONE and ERROR are terminal; only reset leaves them.
REQ-025 Gaps (in_valid low) of any length inside a word are allowed; the partial word and byte index are retained.
REQ-026 Address arithmetic is modulo 2^32; wrap is not flagged.

Reset
REQ-027 When reset is low at a clock edge, the following are forced: state=LEN, byte index=0, words_loaded=0, setup_write=0, setup_address=0, setup_data_in=0, core_hold=1, load_done=0, load_error=0, running checksum=0.
REQ-028 Reset asserted mid-word or mid-image discards all partial state. Words already written stay in memory.

Configuration
REQ-029 Macro LOADER_CHECKSUM_EN.
REQ-030 When defined:
- A running 32-bit sum (modulo 2^32) accumulates each written word.
- CHECK assembles one further 4-byte little-endian word.
- Match -> DONE; mismatch -> ERROR.
REQ-031 When undefined: the CHECK state and the checksum register are absent, and the last WRITE (or N==0) goes directly to DONE.

Structure
REQ-032 Shared package loader_pkg holds the state enum loader_state_t and the constant LOADER_BYTES_PER_WORD=4.
REQ-033 One sub-module, byte_assembler: shift-in of 4 bytes to a 32-bit word, with word_valid pulse and clear.
REQ-034 setup_address and setup_data_in use the codebase architectural register type.

Verification
REQ-035 Scenario: N=2, words 32'h00000093, 32'h00100113, BASE_ADDR=0 -> writes (0,00000093) then (4,00100113); words_loaded=2; load_done=1; core_hold=0 one cycle after the last WRITE (or CHECK).
REQ-036 Scenario: N=0 -> no setup_write; load_done=1. With LOADER_CHECKSUM_EN, the checksum 32'h0 is sent first.
REQ-037 Scenario: N=MAX_WORDS+1 -> load_error=1, core_hold=1, no setup_write, in_ready=0 thereafter.
REQ-038 Scenario: in_valid toggled every other cycle during a word -> the same write as with back-to-back bytes; in_ready=0 during WRITE.
REQ-039 Scenario: reset pulsed low after 2 data bytes -> all outputs return to reset values; a subsequent full image loads correctly from BASE_ADDR.
REQ-040 Scenario (LOADER_CHECKSUM_EN): words 1,2 with checksum 3 -> load_done=1; with checksum 4 -> load_error=1, core_hold=1.
